// File: rtl/hub75_frame_loader.sv
// Bridges SPI pixel words into the system clock and sequences linear writes into the HUB75 back buffer.
// Optional frame/drop statistics counters are enabled by defining HUB75_FRAME_COUNT_EN.
module hub75_frame_loader #(
    parameter int          WIDTH  = 64,
    parameter int          HEIGHT = 32,
    parameter int          ADDR_W = 11,
    parameter logic [15:0] MARKER = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       spi_data,
    input  logic              spi_pixel_clk,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [15:0]       fb_wdata,
    output logic              swap_req,
    input  logic              swap_ack,
    output logic              frame_active,
    output logic              sync_error,
    output logic              overrun,
    input  logic              clear_overrun
`ifdef HUB75_FRAME_COUNT_EN
    ,
    output logic [7:0]        frame_count,
    output logic [7:0]        drop_count
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SWAP_WAIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              s1, s2, s3;
    logic              word_evt;
    logic              is_marker;
    logic              drop_evt;

    assign is_marker = (spi_data == MARKER);
    assign drop_evt  = word_evt && (state == SWAP_WAIT);

    // Stage 0: strobe synchroniser and registered falling-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            word_evt <= 1'b0;
        end else begin
            s1       <= spi_pixel_clk;
            s2       <= s1;
            s3       <= s2;
            word_evt <= s3 & ~s2;
        end
    end

    // Stage 1: word handling; spi_data is quasi-static by the word_evt cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fb_wr_en     <= 1'b0;
            fb_waddr     <= '0;
            fb_wdata     <= '0;
            swap_req     <= 1'b0;
            frame_active <= 1'b0;
            sync_error   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            fb_wr_en   <= 1'b0;
            sync_error <= 1'b0;

            if (drop_evt)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (word_evt && is_marker) begin
                        state        <= LOAD;
                        cnt          <= '0;
                        frame_active <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_evt) begin
                        if (is_marker) begin
                            sync_error <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            fb_wr_en <= 1'b1;
                            fb_waddr <= cnt;
                            fb_wdata <= spi_data;
                            cnt      <= cnt + ADDR_W'(1);
                            if (cnt == LAST_ADDR) begin
                                state        <= SWAP_WAIT;
                                frame_active <= 1'b0;
                                cnt          <= '0;
                            end
                        end
                    end
                end
                SWAP_WAIT: begin
                    // swap_req rises one cycle after the final write, so an ack is never seen early
                    if (!swap_req) begin
                        swap_req <= 1'b1;
                    end else if (swap_ack) begin
                        swap_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HUB75_FRAME_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic ack_evt;
    assign ack_evt = (state == SWAP_WAIT) && swap_req && swap_ack;

    // Stage 2: statistics; a drop in the clear cycle still counts once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 8'd0;
            drop_count  <= 8'd0;
        end else begin
            if (ack_evt)
                frame_count <= frame_count + 8'd1;
            if (clear_overrun)
                drop_count <= drop_evt ? 8'd1 : 8'd0;
            else if (drop_evt)
                drop_count <= sat_inc8(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Directed-plus-random bench for hub75_frame_loader against a word-level model of the loader.
module tb_hub75_frame_loader;

    localparam int          WIDTH  = 4;
    localparam int          HEIGHT = 2;
    localparam int          ADDR_W = 3;
    localparam int          NPIX   = WIDTH * HEIGHT;
    localparam logic [15:0] MARKER = 16'hFFFF;
    localparam int          M_IDLE = 0;
    localparam int          M_LOAD = 1;
    localparam int          M_WAIT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [15:0]       spi_data;
    logic              spi_pixel_clk;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_waddr;
    logic [15:0]       fb_wdata;
    logic              swap_req;
    logic              swap_ack;
    logic              frame_active;
    logic              sync_error;
    logic              overrun;
    logic              clear_overrun;
`ifdef HUB75_FRAME_COUNT_EN
    logic [7:0]        frame_count;
    logic [7:0]        drop_count;
`endif

    always #5 clk = ~clk;

    hub75_frame_loader #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W),
        .MARKER(MARKER)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_data     (spi_data),
        .spi_pixel_clk(spi_pixel_clk),
        .fb_wr_en     (fb_wr_en),
        .fb_waddr     (fb_waddr),
        .fb_wdata     (fb_wdata),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .frame_active (frame_active),
        .sync_error   (sync_error),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
`ifdef HUB75_FRAME_COUNT_EN
        ,
        .frame_count  (frame_count),
        .drop_count   (drop_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int sync_total = 0;

    // Word-level model state
    int          m_mode = M_IDLE;
    int          m_cnt = 0;
    int          m_addr = 0;
    logic [15:0] m_data = 16'h0;
    int          m_ovr = 0;
    int          m_wr_total = 0;
    int          m_sync_total = 0;
    int          m_frames = 0;
    int          m_drops = 0;

    initial forever begin
        @(negedge clk);
        if (fb_wr_en === 1'b1) wr_total++;
        if (sync_error === 1'b1) sync_total++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(input logic [15:0] w, input bit clr, output bit wr, output bit se);
        bit dropped;
        wr = 1'b0;
        se = 1'b0;
        dropped = 1'b0;
        case (m_mode)
            M_IDLE: if (w == MARKER) begin m_mode = M_LOAD; m_cnt = 0; end
            M_LOAD: begin
                if (w == MARKER) begin
                    se = 1'b1;
                    m_cnt = 0;
                    m_sync_total++;
                end else begin
                    wr = 1'b1;
                    m_addr = m_cnt;
                    m_data = w;
                    m_cnt++;
                    m_wr_total++;
                    if (m_cnt == NPIX) m_mode = M_WAIT;
                end
            end
            default: begin dropped = 1'b1; m_ovr = 1; end
        endcase
        if (clr && !dropped) m_ovr = 0;
        if (clr) m_drops = dropped ? 1 : 0;
        else if (dropped && m_drops < 255) m_drops++;
    endtask

    task automatic send_word(input logic [15:0] w, input bit clr);
        bit exp_wr, exp_se;
        int pre_mode;
        pre_mode = m_mode;
        model_word(w, clr, exp_wr, exp_se);
        @(negedge clk);
        spi_data = w;
        spi_pixel_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wr_en_early", 32'(fb_wr_en), 32'd0);
        if (clr) clear_overrun = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("wr_en", 32'(fb_wr_en), 32'(exp_wr));
        chk("waddr", 32'(fb_waddr), 32'(m_addr));
        if (exp_wr) chk("wdata", 32'(fb_wdata), 32'(m_data));
        chk("sync_error", 32'(sync_error), 32'(exp_se));
        chk("frame_active", 32'(frame_active), 32'(m_mode == M_LOAD));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("swap_req_wr", 32'(swap_req), 32'(pre_mode == M_WAIT));
        @(negedge clk);
        chk("wr_en_single", 32'(fb_wr_en), 32'd0);
        chk("swap_req_next", 32'(swap_req), 32'(m_mode == M_WAIT));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        spi_pixel_clk = 1'b1;
        repeat ($urandom_range(3, 5)) @(negedge clk);
    endtask

    task automatic do_swap(input int hold);
        chk("swap_req_start", 32'(swap_req), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("swap_req_hold", 32'(swap_req), 32'd1);
        end
        swap_ack = 1'b1;
        @(negedge clk);
        swap_ack = 1'b0;
        m_mode = M_IDLE;
        m_frames++;
        chk("swap_req_fall", 32'(swap_req), 32'd0);
        chk("frame_active_idle", 32'(frame_active), 32'd0);
        @(negedge clk);
        chk("swap_req_low", 32'(swap_req), 32'd0);
    endtask

    function automatic logic [15:0] rand_pix();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == MARKER) w = 16'hFFFE;
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(fb_wr_en), 32'd0);
        chk({tag, "_waddr"}, 32'(fb_waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(fb_wdata), 32'd0);
        chk({tag, "_swap_req"}, 32'(swap_req), 32'd0);
        chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        chk({tag, "_sync_error"}, 32'(sync_error), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int wr_base;
        int guard;
        reset_n = 1'b0;
        spi_pixel_clk = 1'b1;
        spi_data = 16'h0;
        swap_ack = 1'b0;
        clear_overrun = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Garbage word dropped in IDLE, then a directed frame 0001..0008
        send_word(16'h1234, 1'b0);
        send_word(MARKER, 1'b0);
        for (int i = 1; i <= NPIX; i++) send_word(16'(i), 1'b0);
        do_swap(20);

        // Ack while no swap is pending must be ignored
        @(negedge clk);
        swap_ack = 1'b1;
        @(negedge clk);
        swap_ack = 1'b0;
        chk("idle_ack_swap_req", 32'(swap_req), 32'd0);
        chk("idle_ack_frame_active", 32'(frame_active), 32'd0);

        // Mid-frame marker restarts the frame
        wr_base = wr_total;
        send_word(MARKER, 1'b0);
        for (int i = 0; i < 3; i++) send_word(rand_pix(), 1'b0);
        send_word(MARKER, 1'b0);
        for (int i = 0; i < NPIX; i++) send_word(rand_pix(), 1'b0);

        // Words in SWAP_WAIT are dropped; set beats a coincident clear
        send_word(rand_pix(), 1'b0);
        send_word(MARKER, 1'b0);
        send_word(rand_pix(), 1'b1);
        @(negedge clk);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        m_ovr = 0;
        m_drops = 0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        do_swap(3);
        chk("segment_writes", 32'(wr_total - wr_base), 32'd11);

        // Random frames with occasional restarts
        for (int f = 0; f < 2; f++) begin
            send_word(MARKER, 1'b0);
            guard = 0;
            while (m_mode != M_WAIT && guard < 40) begin
                if ($urandom_range(0, 9) == 0) send_word(MARKER, 1'b0);
                else send_word(rand_pix(), 1'b0);
                guard++;
            end
            chk("random_frame_done", 32'(m_mode), 32'(M_WAIT));
            do_swap($urandom_range(0, 5));
        end

        // Asynchronous reset while loading, last write at addr 5
        send_word(MARKER, 1'b0);
        for (int i = 0; i < 6; i++) send_word(rand_pix(), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        m_mode = M_IDLE;
        m_cnt = 0;
        m_addr = 0;
        m_ovr = 0;
        m_drops = 0;
        repeat (4) @(negedge clk);
        send_word(16'h00AB, 1'b0);
        send_word(MARKER, 1'b0);
        for (int i = 0; i < NPIX; i++) send_word(rand_pix(), 1'b0);
        do_swap(2);

        repeat (3) @(negedge clk);
        chk("total_writes", 32'(wr_total), 32'(m_wr_total));
        chk("total_sync_errors", 32'(sync_total), 32'(m_sync_total));
`ifdef HUB75_FRAME_COUNT_EN
        chk("frame_count", 32'(frame_count), 32'(m_frames % 256));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
